// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the core-side masters and the memory port.
// The master modport drives a request; the slave modport answers it.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      valid;
  logic                      ready;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   we;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (output valid, addr, wdata, we, input ready, rdata);
  modport slave  (input valid, addr, wdata, we, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter merging imem and dmem onto one memory port.
// Request fields are latched at grant time; a saturating watchdog flags a
// slave that keeps the port busy for too long.
//
// state | meaning
// IDLE  | no transaction outstanding, arbitrating incoming requests
// BUSY  | latched request presented on mem, waiting for mem.ready
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     imem,
  mem_arbiter_if.slave     dmem,
  mem_arbiter_if.master    mem,
  output logic             grant_o,
  output logic             timeout_o
);

  localparam int WE_WIDTH = DATA_WIDTH / 8;
  localparam int CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  load;
  logic                  sel;
  logic                  grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WE_WIDTH-1:0]   we_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  timeout_q;

  // Next state and grant selection; in a completion cycle only the other master may win.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sel     = grant_q;
    case (state_q)
      IDLE: begin
        if (imem.valid || dmem.valid) begin
          load    = 1'b1;
          state_d = BUSY;
          if (imem.valid && dmem.valid) sel = ~grant_q;
          else                          sel = dmem.valid;
        end
      end
      BUSY: begin
        if (mem.ready) begin
          sel = ~grant_q;
          if (grant_q ? imem.valid : dmem.valid) load    = 1'b1;
          else                                   state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant owner and latched request fields, captured only when a master is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else if (load) begin
      grant_q <= sel;
      addr_q  <= sel ? dmem.addr  : imem.addr;
      wdata_q <= sel ? dmem.wdata : imem.wdata;
      we_q    <= sel ? dmem.we    : imem.we;
    end
  end

  // Wait counter: counts stalled BUSY cycles, clears on completion, saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == BUSY) begin
      if (mem.ready)              cnt_d = '0;
      else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog registers; the flag is sticky until reset and never aborts the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if ((TIMEOUT_CYCLES != 0) && (cnt_d == CNT_MAX)) timeout_q <= 1'b1;
    end
  end

  // Port outputs; completion pulses are suppressed while reset abandons the transfer.
  always_comb begin
    mem.valid  = (state_q == BUSY);
    imem.ready = (state_q == BUSY) && mem.ready && !rst && !grant_q;
    dmem.ready = (state_q == BUSY) && mem.ready && !rst &&  grant_q;
  end

  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign mem.we     = we_q;
  assign imem.rdata = mem.rdata;
  assign dmem.rdata = mem.rdata;
  assign grant_o    = grant_q;
  assign timeout_o  = timeout_q;

endmodule
